// File: rtl/pred_pkg.sv
// Shared types, counter reset constants and saturating-counter helpers for
// the tournament branch predictor.
package pred_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_LOCAL  = 2'd1,
        MODE_GLOBAL = 2'd2,
        MODE_HYBRID = 2'd3
    } mode_e;

    // Counters are handled through an 8-bit working width, so CTR_BITS <= 8.
    localparam int CTR_WORK_BITS = 8;

    // Value just below the taken threshold: weakly not-taken for direction
    // tables, weakly "prefer local" for the meta chooser.
    function automatic logic [7:0] ctr_weak_low(input int bits);
        return 8'((1 << (bits - 1)) - 1);
    endfunction

    // Increment, sticking at max_v rather than wrapping to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] ctr, input logic [7:0] max_v);
        return (ctr >= max_v) ? max_v : ctr + 8'd1;
    endfunction

    // Decrement, sticking at zero rather than wrapping to max.
    function automatic logic [7:0] sat_dec(input logic [7:0] ctr);
        return (ctr == 8'd0) ? 8'd0 : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating counters: one combinational read port returning the
// counter MSB, one write port that nudges a counter up or down.
module bp_counter_table
    import pred_pkg::*;
#(
    parameter int                  IDX      = 8,
    parameter int                  CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] INIT     = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] rd_idx_i,
    output logic           rd_taken_o,
    input  logic           wr_en_i,
    input  logic [IDX-1:0] wr_idx_i,
    input  logic           wr_up_i
);

    localparam int         DEPTH   = 1 << IDX;
    localparam logic [7:0] CTR_MAX = 8'((1 << CTR_BITS) - 1);

    logic [CTR_BITS-1:0] ctr_q [DEPTH];
    logic [CTR_BITS-1:0] wr_cur_s;
    logic [CTR_BITS-1:0] ctr_d;

    // The read sees the table as it stood before this edge's write.
    assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];
    assign wr_cur_s   = ctr_q[wr_idx_i];

    // Next value of the counter being trained.
    always_comb begin
        ctr_d = wr_cur_s;
        if (wr_up_i) begin
            ctr_d = CTR_BITS'(sat_inc(8'(wr_cur_s), CTR_MAX));
        end else begin
            ctr_d = CTR_BITS'(sat_dec(8'(wr_cur_s)));
        end
    end

    // Counter storage with asynchronous reset to INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= INIT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: per-PC local history, gshare global history,
// meta chooser and a tagged direct-mapped BTB. Lookup result is registered
// one cycle after the fetch PC; training arrives from MEM.
module tournament_predictor
    import pred_pkg::*;
#(
    parameter int GHR_BITS = 8,
    parameter int LHR_BITS = 6,
    parameter int LHT_IDX  = 7,
    parameter int META_IDX = 8,
    parameter int BTB_IDX  = 6,
    parameter int CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic [1:0]  Mode,
    input  logic        Lookup_valid,
    input  logic [31:0] Lookup_PC,
    input  logic        Lookup_is_br,
    input  logic        Lookup_is_jmp,
    input  logic        Upd_valid,
    input  logic [31:0] Upd_PC,
    input  logic        Upd_is_br,
    input  logic        Upd_taken,
    input  logic [31:0] Upd_target,
    input  logic [1:0]  Upd_pred,
    output logic        Taken,
    output logic [31:0] Taken_addr,
    output logic [1:0]  Pred_OUT
);

    localparam int                  TAG_BITS = 30 - BTB_IDX;
    localparam int                  LHT_N    = 1 << LHT_IDX;
    localparam int                  BTB_N    = 1 << BTB_IDX;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_low(CTR_BITS));

    // Architectural state held here; counter tables live in sub-modules.
    logic [GHR_BITS-1:0] ghr_q;
    logic [LHR_BITS-1:0] lht_q       [LHT_N];
    logic [BTB_N-1:0]    btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q   [BTB_N];
    logic [31:0]         btb_tgt_q   [BTB_N];

    logic        taken_q,      taken_d;
    logic [31:0] taken_addr_q, taken_addr_d;
    logic [1:0]  pred_q,       pred_d;

    // Lookup-side indices (PC bits are truncated, word aligned).
    logic [LHR_BITS-1:0] lk_hist_s;
    logic [GHR_BITS-1:0] lk_g_idx_s;
    logic [BTB_IDX-1:0]  lk_b_idx_s;
    logic                lk_local_s, lk_global_s, lk_meta_s, lk_dir_s, lk_hit_s;

    assign lk_hist_s  = lht_q[Lookup_PC[LHT_IDX+1:2]];
    assign lk_g_idx_s = Lookup_PC[GHR_BITS+1:2] ^ ghr_q;
    assign lk_b_idx_s = Lookup_PC[BTB_IDX+1:2];

    // Update-side indices, all formed from pre-update history.
    logic [LHT_IDX-1:0]  up_lht_idx_s;
    logic [LHR_BITS-1:0] up_hist_s;
    logic [GHR_BITS-1:0] up_g_idx_s;
    logic [BTB_IDX-1:0]  up_b_idx_s;
    logic                dir_train_s, meta_train_s, meta_up_s, btb_wr_s;

    assign up_lht_idx_s = Upd_PC[LHT_IDX+1:2];
    assign up_hist_s    = lht_q[up_lht_idx_s];
    assign up_g_idx_s   = Upd_PC[GHR_BITS+1:2] ^ ghr_q;
    assign up_b_idx_s   = Upd_PC[BTB_IDX+1:2];
    assign dir_train_s  = Upd_valid & Upd_is_br;
    // Meta only learns when the two components disagreed; +1 favours global.
    assign meta_train_s = dir_train_s & (Upd_pred[1] ^ Upd_pred[0]);
    assign meta_up_s    = (Upd_pred[1] == Upd_taken);
    assign btb_wr_s     = Upd_valid & Upd_taken;

    // Byte-offset bits of the PCs carry no information for the predictor.
    logic unused_pc_lsbs_s;
    assign unused_pc_lsbs_s = ^{Lookup_PC[1:0], Upd_PC[1:0]};

    bp_counter_table #(.IDX(LHR_BITS), .CTR_BITS(CTR_BITS), .INIT(CTR_INIT)) u_lpht (
        .clk(CLK), .rst(RESET),
        .rd_idx_i(lk_hist_s), .rd_taken_o(lk_local_s),
        .wr_en_i(dir_train_s), .wr_idx_i(up_hist_s), .wr_up_i(Upd_taken)
    );

    bp_counter_table #(.IDX(GHR_BITS), .CTR_BITS(CTR_BITS), .INIT(CTR_INIT)) u_gpht (
        .clk(CLK), .rst(RESET),
        .rd_idx_i(lk_g_idx_s), .rd_taken_o(lk_global_s),
        .wr_en_i(dir_train_s), .wr_idx_i(up_g_idx_s), .wr_up_i(Upd_taken)
    );

    bp_counter_table #(.IDX(META_IDX), .CTR_BITS(CTR_BITS), .INIT(CTR_INIT)) u_meta (
        .clk(CLK), .rst(RESET),
        .rd_idx_i(Lookup_PC[META_IDX+1:2]), .rd_taken_o(lk_meta_s),
        .wr_en_i(meta_train_s), .wr_idx_i(Upd_PC[META_IDX+1:2]), .wr_up_i(meta_up_s)
    );

    // Direction selection by mode, BTB hit test and next output values.
    always_comb begin
        lk_dir_s = 1'b0;
        case (mode_e'(Mode))
            MODE_STATIC: lk_dir_s = 1'b0;
            MODE_LOCAL:  lk_dir_s = lk_local_s;
            MODE_GLOBAL: lk_dir_s = lk_global_s;
            MODE_HYBRID: lk_dir_s = lk_meta_s ? lk_global_s : lk_local_s;
            default:     lk_dir_s = 1'b0;
        endcase
        lk_hit_s     = btb_valid_q[lk_b_idx_s] &&
                       (btb_tag_q[lk_b_idx_s] == Lookup_PC[31:BTB_IDX+2]);
        taken_d      = ((Lookup_is_br & lk_dir_s) | Lookup_is_jmp) & lk_hit_s;
        taken_addr_d = lk_hit_s ? btb_tgt_q[lk_b_idx_s] : 32'd0;
        pred_d       = {lk_global_s, lk_local_s};
    end

    // Registered prediction outputs: cleared by flush, held while idle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            taken_q      <= 1'b0;
            taken_addr_q <= 32'd0;
            pred_q       <= 2'b00;
        end else if (FLUSH) begin
            taken_q      <= 1'b0;
            taken_addr_q <= 32'd0;
            pred_q       <= 2'b00;
        end else if (Lookup_valid) begin
            taken_q      <= taken_d;
            taken_addr_q <= taken_addr_d;
            pred_q       <= pred_d;
        end
    end

    // History registers and BTB training; flush never touches these.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ghr_q       <= '0;
            btb_valid_q <= '0;
            for (int i = 0; i < LHT_N; i++) begin
                lht_q[i] <= '0;
            end
            for (int i = 0; i < BTB_N; i++) begin
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= 32'd0;
            end
        end else begin
            if (dir_train_s) begin
                ghr_q               <= {ghr_q[GHR_BITS-2:0], Upd_taken};
                lht_q[up_lht_idx_s] <= {up_hist_s[LHR_BITS-2:0], Upd_taken};
            end
            if (btb_wr_s) begin
                btb_valid_q[up_b_idx_s] <= 1'b1;
                btb_tag_q[up_b_idx_s]   <= Upd_PC[31:BTB_IDX+2];
                btb_tgt_q[up_b_idx_s]   <= Upd_target;
            end
        end
    end

    assign Taken      = taken_q;
    assign Taken_addr = taken_addr_q;
    assign Pred_OUT   = pred_q;

endmodule
